// File: rtl/weight_route_scheduler.sv
// weight_route_scheduler: sequences the clear/route/pop/reuse controls of the
// sequential weight router for a batch of N kernels, replaying each kernel's
// weights R times with one consumer-ready handshake per pass.
// Optional watchdog: define WEIGHT_SCHED_TIMEOUT_EN to enable the LOAD/STREAM
// timeout (o_error pulse followed by ABORT); otherwise o_error is tied low.
module weight_route_scheduler #(
   parameter int ADDR_WIDTH     = 8,
   parameter int CNT_WIDTH      = 8,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic                  i_abort,
   input  logic [ADDR_WIDTH-1:0] i_base_addr,
   input  logic [ADDR_WIDTH-1:0] i_kernel_stride,
   input  logic [ADDR_WIDTH-1:0] i_addr_offset,
   input  logic [ADDR_WIDTH-1:0] i_route_size,
   input  logic [CNT_WIDTH-1:0]  i_num_kernels,
   input  logic [CNT_WIDTH-1:0]  i_reuse_count,
   input  logic                  i_route_ready,
   input  logic                  i_route_done,
   input  logic                  i_consumer_ready,
   output logic                  o_reg_clear,
   output logic                  o_fifo_clear,
   output logic                  o_route_en,
   output logic                  o_data_out_en,
   output logic                  o_route_reuse,
   output logic [ADDR_WIDTH-1:0] o_start_addr,
   output logic [ADDR_WIDTH-1:0] o_addr_offset,
   output logic [ADDR_WIDTH-1:0] o_route_size,
   output logic [CNT_WIDTH-1:0]  o_kernel_idx,
   output logic [CNT_WIDTH-1:0]  o_pass_idx,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_error
);

   localparam int CW1 = CNT_WIDTH + 1;

   typedef enum logic [3:0] {
      S_IDLE, S_CLEAR, S_LOAD, S_WAIT, S_STREAM, S_REUSE, S_NEXT, S_DONE, S_ABORT
   } state_t;

   state_t                state_reg, state_next;
   logic [ADDR_WIDTH-1:0] stride_reg, start_addr_reg, offset_reg, size_reg;
   logic [CNT_WIDTH-1:0]  num_reg, reuse_reg, kernel_idx_reg, pass_idx_reg;
   logic                  last_pass, last_kernel, timeout_hit;

   // Counter comparisons are done one bit wider so idx+1 cannot overflow.
   assign last_pass   = ({1'b0, pass_idx_reg} + CW1'(1)) >= {1'b0, reuse_reg};
   assign last_kernel = ({1'b0, kernel_idx_reg} + CW1'(1)) == {1'b0, num_reg};

`ifdef WEIGHT_SCHED_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] to_cnt_reg;
   logic            error_reg;
   logic            timed_state;

   assign timed_state = (state_reg == S_LOAD) || (state_reg == S_STREAM);
   assign timeout_hit = timed_state && (to_cnt_reg == TO_LIMIT);

   // Watchdog: counts cycles spent in LOAD/STREAM, cleared on every state change;
   // the error pulse lands on the cycle the count reaches the limit.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         to_cnt_reg <= '0;
         error_reg  <= 1'b0;
      end else begin
         error_reg <= 1'b0;
         if (state_next != state_reg) begin
            to_cnt_reg <= '0;
         end else if (timed_state) begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
            if (to_cnt_reg == TO_LAST) error_reg <= 1'b1;
         end
      end
   end

   assign o_error = error_reg;
`else
   assign timeout_hit = 1'b0;
   assign o_error     = 1'b0;
`endif

   // Next-state decode; abort overrides everything outside IDLE, watchdog next.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (i_start && !i_abort) begin
               if ((i_num_kernels == '0) || (i_reuse_count == '0)) state_next = S_DONE;
               else                                               state_next = S_CLEAR;
            end
         end
         S_CLEAR:  state_next = S_LOAD;
         S_LOAD:   if (i_route_ready) state_next = S_WAIT;
         S_WAIT:   if (i_consumer_ready) state_next = S_STREAM;
         S_STREAM: if (i_route_done) state_next = last_pass ? S_NEXT : S_REUSE;
         S_REUSE:  state_next = S_WAIT;
         S_NEXT:   state_next = last_kernel ? S_DONE : S_CLEAR;
         S_DONE:   state_next = S_IDLE;
         S_ABORT:  state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
      if (timeout_hit) state_next = S_ABORT;
      if ((state_reg != S_IDLE) && i_abort) state_next = S_ABORT;
   end

   // FSM state plus latched configuration, kernel/pass counters and address.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg      <= S_IDLE;
         stride_reg     <= '0;
         start_addr_reg <= '0;
         offset_reg     <= '0;
         size_reg       <= '0;
         num_reg        <= '0;
         reuse_reg      <= '0;
         kernel_idx_reg <= '0;
         pass_idx_reg   <= '0;
      end else begin
         state_reg <= state_next;
         if ((state_reg == S_IDLE) && (state_next != S_IDLE)) begin
            stride_reg     <= i_kernel_stride;
            start_addr_reg <= i_base_addr;
            offset_reg     <= i_addr_offset;
            size_reg       <= i_route_size;
            num_reg        <= i_num_kernels;
            reuse_reg      <= i_reuse_count;
            kernel_idx_reg <= '0;
            pass_idx_reg   <= '0;
         end
         if ((state_reg == S_REUSE) && (state_next == S_WAIT)) begin
            pass_idx_reg <= pass_idx_reg + CNT_WIDTH'(1);
         end
         if ((state_reg == S_NEXT) && (state_next == S_CLEAR)) begin
            kernel_idx_reg <= kernel_idx_reg + CNT_WIDTH'(1);
            pass_idx_reg   <= '0;
            start_addr_reg <= start_addr_reg + stride_reg;
         end
      end
   end

   // Router controls and status are pure decodes of the state register.
   assign o_reg_clear   = (state_reg == S_CLEAR) || (state_reg == S_ABORT);
   assign o_fifo_clear  = (state_reg == S_ABORT);
   assign o_route_en    = (state_reg == S_LOAD);
   assign o_data_out_en = (state_reg == S_STREAM);
   assign o_route_reuse = (state_reg == S_REUSE);
   assign o_busy        = (state_reg != S_IDLE);
   assign o_done        = (state_reg == S_DONE);

   assign o_start_addr  = start_addr_reg;
   assign o_addr_offset = offset_reg;
   assign o_route_size  = size_reg;
   assign o_kernel_idx  = kernel_idx_reg;
   assign o_pass_idx    = pass_idx_reg;

endmodule
